// File: rtl/memram_arbiter_if.sv
// Signal bundle between memram_arbiter, its two requesters and the memram port.
// Handshake: reqN is held high with stable weN/addrN/wdataN until ackN; ackN is a one-cycle completion pulse.
interface memram_arbiter_if #(
    parameter int AW = 4,
    parameter int DW = 8
);
    logic          req0;
    logic          req1;
    logic          we0;
    logic          we1;
    logic [AW-1:0] addr0;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata0;
    logic [DW-1:0] wdata1;
    logic          ack0;
    logic          ack1;
    logic [DW-1:0] rdata0;
    logic [DW-1:0] rdata1;
    logic          mem_wren;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_write_data;
    logic [DW-1:0] mem_read_data;
    logic          busy;
    logic          owner;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_read_data,
        output ack0, ack1, rdata0, rdata1, mem_wren, mem_address, mem_write_data, busy, owner
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_read_data,
        input  ack0, ack1, rdata0, rdata1, mem_wren, mem_address, mem_write_data, busy, owner
    );
endinterface

// File: rtl/memram_arbiter.sv
// Round-robin two-port arbiter sequencing single-word accesses onto the memram port.
// One transaction in flight: IDLE -> ISSUE -> DONE, ack pulses in the cycle after DONE.
module memram_arbiter #(
    parameter int AW = 4,
    parameter int DW = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    memram_arbiter_if.slave  bus,
    output logic [1:0]       state_o
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          prio_q, prio_d;
    logic          owner_q, owner_d;
    logic          we_q, we_d;
    logic          wren_q, wren_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          ack0_q, ack0_d;
    logic          ack1_q, ack1_d;
    logic [DW-1:0] rdata0_q, rdata0_d;
    logic [DW-1:0] rdata1_q, rdata1_d;

    logic elig0, elig1, grant;

    // A requester still holds req during its own ack cycle; masking keeps it from being re-granted.
    assign elig0 = bus.req0 & ~ack0_q;
    assign elig1 = bus.req1 & ~ack1_q;
    assign grant = (elig0 & elig1) ? prio_q : elig1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            prio_q   <= 1'b0;
            owner_q  <= 1'b0;
            we_q     <= 1'b0;
            wren_q   <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            prio_q   <= prio_d;
            owner_q  <= owner_d;
            we_q     <= we_d;
            wren_q   <= wren_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        prio_d   = prio_q;
        owner_d  = owner_q;
        we_d     = we_q;
        wren_d   = 1'b0;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        case (state_q)
            S_IDLE: begin
                if (elig0 | elig1) begin
                    state_d = S_ISSUE;
                    owner_d = grant;
                    prio_d  = ~grant;
                    we_d    = grant ? bus.we1    : bus.we0;
                    addr_d  = grant ? bus.addr1  : bus.addr0;
                    wdata_d = grant ? bus.wdata1 : bus.wdata0;
                    wren_d  = we_d;
                end
            end
            S_ISSUE: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                // Read data is valid by the edge ending DONE for both combinational and registered memram reads.
                state_d = S_IDLE;
                if (!we_q) begin
                    if (owner_q) rdata1_d = bus.mem_read_data;
                    else         rdata0_d = bus.mem_read_data;
                end
                if (owner_q) ack1_d = 1'b1;
                else         ack0_d = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.ack0           = ack0_q;
    assign bus.ack1           = ack1_q;
    assign bus.rdata0         = rdata0_q;
    assign bus.rdata1         = rdata1_q;
    assign bus.mem_wren       = wren_q;
    assign bus.mem_address    = addr_q;
    assign bus.mem_write_data = wdata_q;
    assign bus.busy           = (state_q != S_IDLE);
    assign bus.owner          = owner_q;
    assign state_o            = state_q;
endmodule

// File: tb/tb_memram_arbiter.sv
// Bench for memram_arbiter: behavioural memram, a transaction-schedule reference model,
// directed scenarios with literal expectations and a randomized two-port phase.
module tb_memram_arbiter;
    localparam int AW = 4;
    localparam int DW = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] state_dbg;

    memram_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    memram_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus),
        .state_o(state_dbg)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // ---------------- clock/reset-side memram with combinational read ----------------
    logic [DW-1:0] init_vals [16];
    logic [DW-1:0] ram [16];
    bit            ram_loaded = 1'b0;

    assign bus.mem_read_data = ram[bus.mem_address];

    always @(posedge clk) begin
        if (!ram_loaded) begin
            for (int i = 0; i < 16; i++) ram[i] <= init_vals[i];
            ram_loaded <= 1'b1;
        end else if (bus.mem_wren) begin
            ram[bus.mem_address] <= bus.mem_write_data;
        end
    end

    // ---------------- reference model: transaction schedule ----------------
    logic [DW-1:0] m_mem [16];
    bit            m_loaded = 1'b0;
    bit            m_busy = 1'b0;
    int            t_grant = 0;
    bit            m_port = 1'b0;
    bit            m_we = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wdata = '0;
    bit [1:0]      m_ack = '0;
    logic [DW-1:0] m_rdata [2];
    bit            m_prio = 1'b0;
    bit            m_owner = 1'b0;
    logic [AW-1:0] m_maddr = '0;
    logic [DW-1:0] m_mwdata = '0;

    always @(posedge clk) begin : model
        bit e0, e1, g;
        bit [1:0] nack;
        cyc++;
        if (!m_loaded) begin
            for (int i = 0; i < 16; i++) m_mem[i] = init_vals[i];
            m_loaded = 1'b1;
        end
        if (!rst_n) begin
            m_busy    = 1'b0;
            m_ack     = '0;
            m_rdata[0] = '0;
            m_rdata[1] = '0;
            m_prio    = 1'b0;
            m_owner   = 1'b0;
            m_maddr   = '0;
            m_mwdata  = '0;
        end else begin
            nack = '0;
            if (m_busy) begin
                if (cyc - t_grant == 2) begin
                    if (!m_we) m_rdata[m_port] = m_mem[m_addr];
                    nack[m_port] = 1'b1;
                    m_busy = 1'b0;
                end
            end else begin
                e0 = bus.req0 && !m_ack[0];
                e1 = bus.req1 && !m_ack[1];
                if (e0 || e1) begin
                    g        = (e0 && e1) ? m_prio : e1;
                    m_busy   = 1'b1;
                    t_grant  = cyc;
                    m_port   = g;
                    m_we     = g ? bus.we1    : bus.we0;
                    m_addr   = g ? bus.addr1  : bus.addr0;
                    m_wdata  = g ? bus.wdata1 : bus.wdata0;
                    m_prio   = !g;
                    m_owner  = g;
                    m_maddr  = m_addr;
                    m_mwdata = m_wdata;
                    if (m_we) m_mem[m_addr] = m_wdata;
                end
            end
            m_ack = nack;
        end
    end

    // ---------------- scoreboard ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    bit chk_en = 1'b0;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("ack0", bus.ack0, m_ack[0]);
            chk("ack1", bus.ack1, m_ack[1]);
            chk("rdata0", bus.rdata0, m_rdata[0]);
            chk("rdata1", bus.rdata1, m_rdata[1]);
            chk("busy", bus.busy, m_busy);
            chk("mem_wren", bus.mem_wren, m_busy && (cyc == t_grant) && m_we);
            chk("owner", bus.owner, m_owner);
            chk("mem_address", bus.mem_address, m_maddr);
            chk("mem_write_data", bus.mem_write_data, m_mwdata);
        end
    end

    // ack monitor used by directed ordering checks
    bit rec_en = 1'b0;
    int ack_port_q [$];
    int ack_cyc_q [$];
    int ack_cnt [2] = '{0, 0};

    always @(negedge clk) begin
        if (bus.ack0) ack_cnt[0]++;
        if (bus.ack1) ack_cnt[1]++;
        if (rec_en && bus.ack0) begin ack_port_q.push_back(0); ack_cyc_q.push_back(cyc); end
        if (rec_en && bus.ack1) begin ack_port_q.push_back(1); ack_cyc_q.push_back(cyc); end
    end

    // ---------------- driver tasks (called at a negedge) ----------------
    task automatic port_access(input bit p, input bit we, input logic [AW-1:0] a,
                               input logic [DW-1:0] d, input bit keep, output int lat);
        int  start;
        bit  got;
        if (p) begin bus.req1 = 1'b1; bus.we1 = we; bus.addr1 = a; bus.wdata1 = d; end
        else   begin bus.req0 = 1'b1; bus.we0 = we; bus.addr0 = a; bus.wdata0 = d; end
        start = cyc;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            got = p ? bus.ack1 : bus.ack0;
        end
        lat = cyc - start;
        if (!got) begin
            n_cmp++;
            n_bad++;
            $display("FAIL ack_timeout port %0d: got no ack expected one within 40 cycles", p);
        end
        if (!keep) begin
            if (p) bus.req1 = 1'b0;
            else   bus.req0 = 1'b0;
        end
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        repeat (n) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic rand_port(input bit p, input int n);
        int gap, lat;
        bit keep;
        gap = $urandom_range(0, 3);
        for (int i = 0; i < n; i++) begin
            repeat (gap) @(negedge clk);
            gap  = $urandom_range(0, 3);
            keep = (gap == 0) && (i < n - 1);
            port_access(p, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)),
                        DW'($urandom), keep, lat);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int lat, lat0, lat1, c1;
        for (int i = 0; i < 16; i++) init_vals[i] = DW'($urandom);
        bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
        bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
        rst_n = 1'b0;
        @(negedge clk);
        chk_en = 1'b1;
        chk("reset_ack0", bus.ack0, 0);
        chk("reset_rdata1", bus.rdata1, 0);
        chk("reset_busy", bus.busy, 0);
        chk("reset_mem_address", bus.mem_address, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // single write then read on port 0
        port_access(0, 1'b1, 4'h0, 8'd52, 1'b0, lat);
        chk("t1_write_latency", lat, 3);
        @(negedge clk);
        port_access(0, 1'b0, 4'h0, 8'd0, 1'b0, lat);
        chk("t1_read_latency", lat, 3);
        chk("t1_rdata0", bus.rdata0, 8'd52);
        chk("t1_no_ack1", ack_cnt[1], 0);
        @(negedge clk);

        // simultaneous writes right after reset: port 0 first
        do_reset(2);
        fork
            port_access(0, 1'b1, 4'h1, 8'd27, 1'b0, lat0);
            port_access(1, 1'b1, 4'h2, 8'd80, 1'b0, lat1);
        join
        chk("t2_port0_latency", lat0, 3);
        chk("t2_port1_latency", lat1, 6);
        @(negedge clk);
        port_access(0, 1'b0, 4'h1, 8'd0, 1'b0, lat);
        chk("t2_rdata0_addr1", bus.rdata0, 8'd27);
        @(negedge clk);
        port_access(1, 1'b0, 4'h2, 8'd0, 1'b0, lat);
        chk("t2_rdata1_addr2", bus.rdata1, 8'd80);
        @(negedge clk);

        // both ports hold continuous reads
        ack_port_q.delete();
        ack_cyc_q.delete();
        rec_en = 1'b1;
        fork
            for (int i = 0; i < 2; i++) port_access(0, 1'b0, AW'($urandom_range(0, 15)), 8'd0, i < 1, lat0);
            for (int i = 0; i < 2; i++) port_access(1, 1'b0, AW'($urandom_range(0, 15)), 8'd0, i < 1, lat1);
        join
        @(negedge clk);
        rec_en = 1'b0;
        chk("t3_ack_count", ack_port_q.size(), 4);
        for (int i = 1; i < ack_port_q.size(); i++) begin
            chk("t3_alternate", ack_port_q[i] != ack_port_q[i-1], 1);
            chk("t3_spacing", ack_cyc_q[i] - ack_cyc_q[i-1], 3);
        end

        // port 1 holds req1 through its ack, then switches address
        port_access(0, 1'b1, 4'h6, 8'h11, 1'b0, lat);
        @(negedge clk);
        port_access(0, 1'b1, 4'h7, 8'h22, 1'b0, lat);
        @(negedge clk);
        c1 = ack_cnt[1];
        port_access(1, 1'b0, 4'h6, 8'd0, 1'b1, lat);
        chk("t4_first_rdata1", bus.rdata1, 8'h11);
        port_access(1, 1'b0, 4'h7, 8'd0, 1'b0, lat);
        chk("t4_second_latency", lat, 4);
        chk("t4_second_rdata1", bus.rdata1, 8'h22);
        repeat (4) @(negedge clk);
        chk("t4_ack1_count", ack_cnt[1] - c1, 2);

        // cross-port read-after-write, other port's rdata untouched
        port_access(0, 1'b1, 4'h3, 8'hA5, 1'b0, lat);
        @(negedge clk);
        port_access(0, 1'b0, 4'h1, 8'd0, 1'b0, lat);
        chk("t5_rdata0_before", bus.rdata0, 8'd27);
        @(negedge clk);
        port_access(1, 1'b0, 4'h3, 8'd0, 1'b0, lat);
        chk("t5_rdata1", bus.rdata1, 8'hA5);
        chk("t5_rdata0_kept", bus.rdata0, 8'd27);
        @(negedge clk);

        // reset during DONE of a read, with port 1 requesting through reset
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 4'h3;
        @(negedge clk);
        chk("t6_issue_busy", bus.busy, 1);
        @(negedge clk);
        rst_n = 1'b0;
        bus.req0 = 1'b0;
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 4'h3;
        @(negedge clk);
        chk("t6_no_ack0", bus.ack0, 0);
        chk("t6_busy", bus.busy, 0);
        chk("t6_mem_wren", bus.mem_wren, 0);
        chk("t6_rdata0", bus.rdata0, 0);
        chk("t6_rdata1", bus.rdata1, 0);
        @(negedge clk);
        chk("t6_no_grant_in_reset", bus.busy, 0);
        rst_n = 1'b1;
        port_access(1, 1'b0, 4'h3, 8'd0, 1'b0, lat);
        chk("t6_after_reset_latency", lat, 3);
        chk("t6_after_reset_rdata1", bus.rdata1, 8'hA5);
        @(negedge clk);

        // write whose ISSUE ends on the reset edge still commits
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 4'h9; bus.wdata0 = 8'h3C;
        @(negedge clk);
        rst_n = 1'b0;
        bus.req0 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        port_access(0, 1'b0, 4'h9, 8'd0, 1'b0, lat);
        chk("t7_aborted_write_committed", bus.rdata0, 8'h3C);
        @(negedge clk);

        // randomized two-port traffic
        fork
            rand_port(0, 30);
            rand_port(1, 30);
        join
        repeat (6) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/memram_arbiter.md
# memram_arbiter

Two-port arbiter and sequencer for the 16×8 `memram` data memory. It shares the single RAM port between two requesters, nominally the processor core on port 0 and a loader/debug port on port 1. Each requester posts a one-word read or write. The arbiter grants round-robin, drives `memram` for the granted access, returns read data and pulses a per-port acknowledge.

## Interface
Parameters:
- `AW`, 4, address width; RAM depth is 2^AW words.
- `DW`, 8, data width.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `req0`, `req1` in 1: access request; held high with stable `weN/addrN/wdataN` until `ackN`.
- `we0`, `we1` in 1: 1 = write, 0 = read.
- `addr0`, `addr1` in AW: word address.
- `wdata0`, `wdata1` in DW: write data.
- `ack0`, `ack1` out 1: one-cycle completion pulse.
- `rdata0`, `rdata1` out DW: read result; valid while `ackN`=1, then held until that port's next read completes.
- `mem_wren` out 1: to `memram.wren`.
- `mem_address` out AW: to `memram.address`.
- `mem_write_data` out DW: to `memram.write_data`.
- `mem_read_data` in DW: from `memram.read_data`.
- `busy` out 1: high in ISSUE and DONE.
- `owner` out 1: port owning the current or last transaction.

## Operation
- `memram` contract:
  - Writes commit on the rising edge when `wren`=1.
  - `read_data` is valid by the rising edge that ends the cycle after the address is first presented.
  - The arbiter therefore works for both combinational and one-cycle-registered reads.
- States: IDLE, ISSUE, DONE. All `mem_*` outputs are registered.
- IDLE:
  - On an edge with any eligible request, latch the winner's `we/addr/wdata`, set `owner`, and go to ISSUE.
  - A request is eligible when `reqN`=1 and `ackN`=0. This masks the request a requester still holds during its own ack cycle.
- ISSUE (1 cycle):
  - `mem_address`=latched address and `mem_write_data`=latched data.
  - `mem_wren`=latched `we`; the write commits on the edge ending ISSUE.
  - Next state: DONE.
- DONE (1 cycle):
  - `mem_wren`=0 and `mem_address` is held.
  - On the edge ending DONE: for a read, capture `mem_read_data` into `rdata[owner]`; for a write, leave `rdata[owner]` unchanged.
  - On the same edge, set `ack[owner]`=1 for the next cycle only and go to IDLE.
- Round-robin:
  - Pointer `prio` resets to 0.
  - Both requests eligible: grant `prio`.
  - Single eligible request: grant it.
  - After any grant, `prio` = the port not granted.
- Only one transaction is in flight. A request arriving while busy waits in place; there is no queueing.
- `mem_address` and `mem_write_data` hold their last values in IDLE; `mem_wren` is 0 outside ISSUE.

## Timing
- Reset values: `ack0`=`ack1`=0, `rdata0`=`rdata1`=0, `mem_wren`=0, `mem_address`=0, `mem_write_data`=0, `busy`=0, `owner`=0, state IDLE, `prio`=0.
- Request first sampled at edge E0 (state IDLE):
  - ISSUE during E0–E1; the write commits at E1.
  - DONE during E1–E2.
  - `ackN` high during E2–E3.
  - Latency is 3 cycles from the sampling edge to the ack cycle.
- Throughput: one access per 3 cycles. A new request sampled at E3 (the edge ending the ack cycle) enters ISSUE at E3.
- Same-port back-to-back: the requester may present a new request with the ack cycle's following edge. The masking rule prevents a double grant of the old request.
- Read-after-write to the same address, in consecutive transactions from either port, returns the new data.
- Reset mid-operation:
  - On the reset edge, state returns to IDLE, `mem_wren` goes to 0 and no ack is issued for the aborted transaction.
  - A write whose ISSUE cycle ends on the reset edge still commits, because `memram` samples `mem_wren`=1 on that edge.
- `rst_n` low with `reqN` high: no grant until the first edge with `rst_n`=1.

## Test plan
- Single write then read, port 0: write addr 4'h0 = 52, then read 4'h0. `ack0` is high 3 cycles after each sampling edge, `rdata0`=52, and `ack1` never asserts.
- Simultaneous requests after reset: port 0 writes addr 1 = 27 and port 1 writes addr 2 = 80. Port 0 is granted first (`owner`=0), then port 1. Reads of addresses 1 and 2 return 27 and 80.
- Both ports hold continuous read requests for 12 cycles: acks alternate 0,1,0,1 with one ack every 3 cycles, and no port is granted twice in a row.
- Port 1 holds `req1` through its ack, then changes to a new address: exactly one ack per request, and the second read returns the new address's data.
- Read of addr 3 by port 1 after port 0 wrote 0xA5 there: `rdata1`=0xA5, and `rdata0` keeps its prior value.
- `rst_n` driven low during DONE of a read: no ack; `busy`, `mem_wren` and `rdata*` are 0 after the edge; and a fresh request after reset completes normally.
